// File: rtl/weight_tile_loader_if.sv
// rtl/weight_tile_loader_if.sv - signal bundle between controller, weight memory, weight FIFO and tile loader
// Purpose: groups the tile loader's handshake, memory-read and FIFO-write signals.
// Ports (slave = loader side):
//   start, base_addr        controller -> loader tile request
//   busy, done              loader -> controller status
//   mem_rd_en, mem_rd_addr  loader -> weight memory read request
//   mem_rd_data             weight memory -> loader, one cycle after mem_rd_en
//   push_col*, data_col*    loader -> three column FIFOs
//   pop, load_en            loader -> FIFO pop and MMU weight-load window
//   fifo_count              tracked FIFO occupancy
interface weight_tile_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [23:0]       mem_rd_data;
    logic              push_col0;
    logic              push_col1;
    logic              push_col2;
    logic [7:0]        data_col0;
    logic [7:0]        data_col1;
    logic [7:0]        data_col2;
    logic              pop;
    logic              load_en;
    logic [FC_W-1:0]   fifo_count;

    modport master (
        output start, base_addr, mem_rd_data,
        input  busy, done, mem_rd_en, mem_rd_addr,
        input  push_col0, push_col1, push_col2,
        input  data_col0, data_col1, data_col2,
        input  pop, load_en, fifo_count
    );

    modport slave (
        input  start, base_addr, mem_rd_data,
        output busy, done, mem_rd_en, mem_rd_addr,
        output push_col0, push_col1, push_col2,
        output data_col0, data_col1, data_col2,
        output pop, load_en, fifo_count
    );
endinterface

// File: rtl/weight_tile_loader.sv
// rtl/weight_tile_loader.sv - writer side of the 3-column weight FIFO feeding the 3x3 MMU
// Purpose: on start, reads a ROWS x 3 weight tile (one row per address), pushes each
//   row into the three column queues, then issues the pop burst that loads the
//   systolic array and holds load_en through the column-skew drain.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; the FIFO reset must come from ~rst
//   bus   weight_tile_loader_if slave modport (start/base_addr in, status,
//         memory read, FIFO push/pop, load_en and fifo_count out)
module weight_tile_loader #(
    parameter int ROWS   = 3,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int SKEW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    weight_tile_loader_if.slave bus
);
    generate
        if (ROWS < 1 || ROWS > DEPTH) begin : g_bad_rows
            $error("weight_tile_loader: ROWS must be in 1..DEPTH");
        end
    endgenerate

    localparam int CNT_MAX = (ROWS > SKEW) ? ROWS : SKEW;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FC_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_SKEW = CNT_W'((SKEW > 0) ? (SKEW - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST_PUSH,
        S_POP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_base;
    logic              r_push;
    logic [FC_W-1:0]   r_fifo_count;
    logic              w_latch_base;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_load_en;
    logic              w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_push       <= 1'b0;
            r_fifo_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_base) begin
                r_base <= bus.base_addr;
            end
            // Memory has one cycle of read latency, so the push trails the read strobe.
            r_push <= w_rd_en;
            case ({r_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + FC_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - FC_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // One shared counter walks the FETCH, POP and DRAIN phases; it is cleared on every
    // state change so each phase starts counting from zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = '0;
        w_latch_base = 1'b0;
        w_rd_en      = 1'b0;
        w_pop        = 1'b0;
        w_load_en    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_latch_base = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                if (r_cnt == LAST_ROW) begin
                    w_state_nxt = S_LAST_PUSH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LAST_PUSH: begin
                w_state_nxt = S_POP;
            end
            S_POP: begin
                w_pop     = 1'b1;
                w_load_en = 1'b1;
                if (r_cnt == LAST_ROW) begin
                    w_state_nxt = (SKEW == 0) ? S_DONE : S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // Keeps load_en up while column 2's double skew flushes through the array.
                w_load_en = 1'b1;
                if (r_cnt == LAST_SKEW) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = w_done;
    assign bus.mem_rd_en   = w_rd_en;
    // Address wraps modulo 2^ADDR_W; it reads as zero outside FETCH.
    assign bus.mem_rd_addr = w_rd_en ? (r_base + ADDR_W'(r_cnt)) : '0;
    assign bus.push_col0   = r_push;
    assign bus.push_col1   = r_push;
    assign bus.push_col2   = r_push;
    assign bus.data_col0   = bus.mem_rd_data[7:0];
    assign bus.data_col1   = bus.mem_rd_data[15:8];
    assign bus.data_col2   = bus.mem_rd_data[23:16];
    assign bus.pop         = w_pop;
    assign bus.load_en     = w_load_en;
    assign bus.fifo_count  = r_fifo_count;

    a_no_push_with_pop: assert property (@(posedge clk) disable iff (rst) !(r_push && w_pop));
    a_no_overflow:      assert property (@(posedge clk) disable iff (rst) r_fifo_count <= FC_W'(DEPTH));
    a_no_underflow:     assert property (@(posedge clk) disable iff (rst) !(w_pop && r_fifo_count == '0));
endmodule
